aes_decryptor: RTL and testbench
================================

Name: aes_decryptor

Overview:
- Iterative AES-128 decryptor: recovers 128-bit plaintext from 128-bit ciphertext and the same 128-bit cipher key that the encryptor uses.
- Completes one inverse round per clock.
- Derives the final round key internally with a forward key-expansion pass, then walks the key schedule backwards on the fly.
- Sits alongside the encryptor as the receive-side datapath; start/done handshake to the host controller.

Parameters:
- NR, 10, round count; only 10 (AES-128) legal, elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  request pulse; sampled only when ready=1.
- ciphertext  input  128  block to decrypt; bits [127:120] are state byte 0; state is column-major per FIPS-197.
- key  input  128  cipher key, same byte order as ciphertext.
- ready  output  1  high in IDLE; a start is accepted only then.
- plaintext  output  128  result; valid when done=1; held until the next accepted start.
- done  output  1  one-cycle pulse marking plaintext valid.

Behaviour:
- Reset (rst=0 at an edge):
  - state forced to IDLE.
  - ready=1, done=0, plaintext=0.
  - Internal state, round-key and counter registers cleared.
  - Applies mid-operation too: any in-flight block is discarded with no done pulse.
- IDLE:
  - On start=1, latch ciphertext into st and key into rk, clear cnt, go to KEYEXP; ready drops the next cycle.
  - start=0 keeps IDLE.
- KEYEXP, 10 cycles, cnt 0..9:
  - Each edge: rk <= fwd_expand(rk, RCON[cnt+1]), i.e. RotWord, SubWord, XOR rcon, then the XOR chain across the 4 words.
  - On the edge with cnt=9: rk holds round key 10; also st <= st ^ rk10 (initial AddRoundKey); cnt <= 9; go to ROUNDS.
- ROUNDS, 10 cycles, cnt 9 down to 0:
  - nk = inv_expand(rk, RCON[cnt+1]) gives round key cnt.
  - Each edge: rk <= nk.
  - cnt>0: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ nk).
  - cnt=0: st <= InvSubBytes(InvShiftRows(st)) ^ nk, with no InvMixColumns; plaintext <= that value; done <= 1; go to DONE.
- DONE, 1 cycle: done=1; next edge done <= 0 and state returns to IDLE.
- Latency: start sampled at edge E0; done high in the cycle after edge E0+20 (21 edges). Throughput is one block per 22 cycles.
- start while ready=0 is ignored, not queued.
- ciphertext and key may change after the accepting edge; they are not re-sampled.
- inv_expand(rk, rc), words w4..w7 -> w0..w3:
  - w3 = w7^w6, w2 = w6^w5, w1 = w5^w4.
  - w0 = w4 ^ SubWord(RotWord(w3)) ^ {rc,24'h0}.
- GF(2^8) arithmetic: xtime uses reduction polynomial 0x11B. InvMixColumns coefficients are 0e 0b 0d 09.
- All S-box lookups are combinational ROM.

Decomposition:
- Shared package aes_pkg, holding:
  - state FSM enum {IDLE, KEYEXP, ROUNDS, DONE}.
  - RCON constant array, indices 1..10 = 01 02 04 08 10 20 40 80 1b 36.
  - SBOX and INV_SBOX 256-entry constant tables.
  - Functions: xtime, gmul, sub_word, rot_word.
- One sub-module: aes_inv_round.
  - Combinational; inputs st, round key, last flag; output next state.
  - Instantiated once.
- Key logic and FSM stay in the top.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a -> done pulse exactly 21 edges after start, plaintext=00112233445566778899aabbccddeeff.
- FIPS-197 App.B: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32 -> plaintext=3243f6a8885a308d313198a2e0370734; done high exactly one cycle.
- Busy rejection: start held high throughout the C.1 run, with ct/key changed mid-run -> C.1 result unaffected; second block begins only on the first edge where ready=1.
- Reset mid-operation: rst=0 for one edge during ROUNDS cnt=5 -> next cycle ready=1, done=0, plaintext=0; no done pulse; subsequent App.B run correct.
- Back-to-back: start reasserted the cycle ready returns -> two correct results with done pulses 22 cycles apart; plaintext holds the first result until the second start is accepted.
- Round-trip: 50 random key/plaintext pairs through the encryptor, outputs into aes_decryptor -> original plaintext recovered every time.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants, S-box ROMs and
// the GF(2^8) / word helpers used by the key schedule and the inverse round.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUNDS = 2'd2,
    DONE   = 2'd3
  } aes_state_e;

  // Index 0 is unused so RCON[i] matches the round number.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] st_o
);

  logic [127:0] sb;
  logic [127:0] ark;

  function automatic logic [7:0] bt(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction

  // Byte 4*c+r is row r of column c; row r rotates right by r columns.
  always_comb begin
    sb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[127-8*(4*c+r) -: 8] = INV_SBOX[bt(st_i, 4*((c+4-r)%4)+r)];
      end
    end
    ark = sb ^ rk_i;
  end

  always_comb begin
    st_o = ark;
    if (!last_i) begin
      for (int c = 0; c < 4; c++) begin
        st_o[127-32*c -: 8] = gmul(8'h0e, bt(ark, 4*c)) ^ gmul(8'h0b, bt(ark, 4*c+1))
                            ^ gmul(8'h0d, bt(ark, 4*c+2)) ^ gmul(8'h09, bt(ark, 4*c+3));
        st_o[119-32*c -: 8] = gmul(8'h09, bt(ark, 4*c)) ^ gmul(8'h0e, bt(ark, 4*c+1))
                            ^ gmul(8'h0b, bt(ark, 4*c+2)) ^ gmul(8'h0d, bt(ark, 4*c+3));
        st_o[111-32*c -: 8] = gmul(8'h0d, bt(ark, 4*c)) ^ gmul(8'h09, bt(ark, 4*c+1))
                            ^ gmul(8'h0e, bt(ark, 4*c+2)) ^ gmul(8'h0b, bt(ark, 4*c+3));
        st_o[103-32*c -: 8] = gmul(8'h0b, bt(ark, 4*c)) ^ gmul(8'h0d, bt(ark, 4*c+1))
                            ^ gmul(8'h09, bt(ark, 4*c+2)) ^ gmul(8'h0e, bt(ark, 4*c+3));
      end
    end
  end

endmodule

// File: rtl/aes_decryptor.sv
// Iterative AES-128 decryptor: forward key expansion to round key 10, then one
// inverse round per clock while the key schedule is walked backwards.
module aes_decryptor
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         ready,
  output logic [127:0] plaintext,
  output logic         done,
  output aes_state_e   dbg_state_o
);

  if (NR != 10) begin : g_nr_check
    $error("aes_decryptor: only NR=10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  aes_state_e   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   rc_idx;
  logic [127:0] fwd_key;
  logic [127:0] inv_key;
  logic [127:0] round_out;

  function automatic logic [127:0] fwd_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one expansion step: words w4..w7 in, words w0..w3 out.
  function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  assign rc_idx  = cnt_q + 4'd1;
  assign fwd_key = fwd_expand(rk_q, RCON[rc_idx]);
  assign inv_key = inv_expand(rk_q, RCON[rc_idx]);

  aes_inv_round u_inv_round (
    .st_i   (st_q),
    .rk_i   (inv_key),
    .last_i (cnt_q == 4'd0),
    .st_o   (round_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      pt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = KEYEXP;
      KEYEXP:  if (cnt_q == LAST_CNT) state_d = ROUNDS;
      ROUNDS:  if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    st_d  = st_q;
    rk_d  = rk_q;
    pt_d  = pt_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          st_d  = ciphertext;
          rk_d  = key;
          cnt_d = '0;
        end
      end
      KEYEXP: begin
        rk_d = fwd_key;
        if (cnt_q == LAST_CNT) begin
          st_d  = st_q ^ fwd_key;
          cnt_d = LAST_CNT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUNDS: begin
        rk_d = inv_key;
        st_d = round_out;
        if (cnt_q == 4'd0) pt_d = round_out;
        else cnt_d = cnt_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ready       = (state_q == IDLE);
    done        = (state_q == DONE);
    plaintext   = pt_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_aes_decryptor.sv
// Bench for aes_decryptor: FIPS-197 vectors, busy/reset/back-to-back cases and
// random round trips through a byte-level AES encryption model.
module tb_aes_decryptor;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic         ready;
  logic [127:0] plaintext;
  logic         done;
  aes_state_e   dbg_state;

  aes_decryptor #(.NR(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ciphertext  (ciphertext),
    .key         (key),
    .ready       (ready),
    .plaintext   (plaintext),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  int           n_checks = 0;
  int           n_pass = 0;
  logic [127:0] exp_q[$];
  int unsigned  acc_q[$];
  int unsigned  done_cyc_q[$];
  logic [127:0] cur_exp = '0;
  logic [7:0]   sbox_m [256];
  bit           prev_done = 1'b0;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // Reference model: GF(2^8) arithmetic, S-box built from inverse + affine map
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbox_m[w[i-4+(j+1)%4]];
        tmp[0] = tmp[0] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gf_mul(8'h02, t[4*c+r]) ^ gf_mul(8'h03, t[4*c+(r+1)%4])
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard monitor: records accepted starts, checks every done pulse
  always @(negedge clk) begin
    logic [127:0] e;
    int unsigned  a;
    #2;
    if (rst && start && ready) begin
      exp_q.push_back(cur_exp);
      acc_q.push_back(cyc + 1);
    end
    if (prev_done) check(!done, "done_one_cycle", 128'(done), 128'(0));
    if (done) begin
      done_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", plaintext, 128'(0));
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check(plaintext === e, "plaintext", plaintext, e);
        check((cyc - a) == 20, "latency_edges", 128'(cyc - a), 128'(20));
      end
    end
    prev_done = done;
  end

  // Driver tasks (inputs change on the falling edge)
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check(1'b0, {name, "_ready_timeout"}, 128'(ready), 128'(1));
  endtask

  task automatic issue(input logic [127:0] k, input logic [127:0] c, input logic [127:0] e);
    key        = k;
    ciphertext = c;
    cur_exp    = e;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic run_block(input string name, input logic [127:0] k, input logic [127:0] c,
                           input logic [127:0] e);
    wait_ready(name);
    issue(k, c, e);
    wait_ready(name);
  endtask

  initial begin
    int unsigned  acc;
    int           n;
    logic [127:0] ka, pa, kb, pb, kr, pr;

    build_sbox();

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check(ready === 1'b1, "reset_ready", 128'(ready), 128'(1));
    check(done === 1'b0, "reset_done", 128'(done), 128'(0));
    check(plaintext === '0, "reset_plaintext", plaintext, 128'(0));
    check(dbg_state === IDLE, "reset_state", 128'(dbg_state), 128'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    check(model_encrypt(C1_KEY, C1_PT) === C1_CT, "model_c1", model_encrypt(C1_KEY, C1_PT), C1_CT);

    // FIPS-197 vectors
    run_block("c1", C1_KEY, C1_CT, C1_PT);
    run_block("appb", B_KEY, B_CT, B_PT);

    // Busy rejection: start held high, inputs changed mid-run
    done_cyc_q.delete();
    wait_ready("busy");
    key = C1_KEY; ciphertext = C1_CT; cur_exp = C1_PT; start = 1'b1;
    repeat (6) @(negedge clk);
    key = B_KEY; ciphertext = B_CT; cur_exp = B_PT;
    n = 0;
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    start = 1'b0;
    wait_ready("busy2");
    check(done_cyc_q.size() == 2, "busy_done_count", 128'(done_cyc_q.size()), 128'(2));
    if (done_cyc_q.size() == 2)
      check(done_cyc_q[1] - done_cyc_q[0] == 22, "busy_done_spacing",
            128'(done_cyc_q[1] - done_cyc_q[0]), 128'(22));

    // Reset during ROUNDS with cnt=5
    wait_ready("rst_mid");
    acc = cyc + 1;
    issue(C1_KEY, C1_CT, C1_PT);
    n = 0;
    while (cyc < acc + 14 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(dbg_state === ROUNDS, "mid_state", 128'(dbg_state), 128'(ROUNDS));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check(ready === 1'b1, "rst_mid_ready", 128'(ready), 128'(1));
    check(done === 1'b0, "rst_mid_done", 128'(done), 128'(0));
    check(plaintext === '0, "rst_mid_plaintext", plaintext, 128'(0));
    exp_q.delete();
    acc_q.delete();
    repeat (30) @(negedge clk);
    run_block("rst_after", B_KEY, B_CT, B_PT);

    // Back-to-back with plaintext hold
    done_cyc_q.delete();
    ka = rand128(); pa = rand128(); kb = rand128(); pb = rand128();
    wait_ready("b2b");
    issue(ka, model_encrypt(ka, pa), pa);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(plaintext === pa, "hold_before_start", plaintext, pa);
    issue(kb, model_encrypt(kb, pb), pb);
    wait_ready("b2b2");
    check(done_cyc_q.size() == 2, "b2b_done_count", 128'(done_cyc_q.size()), 128'(2));
    if (done_cyc_q.size() == 2)
      check(done_cyc_q[1] - done_cyc_q[0] == 22, "b2b_done_spacing",
            128'(done_cyc_q[1] - done_cyc_q[0]), 128'(22));

    // Random round trips
    for (int i = 0; i < 50; i++) begin
      kr = rand128();
      pr = rand128();
      wait_ready("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(kr, model_encrypt(kr, pr), pr);
    end
    wait_ready("rand_end");

    repeat (3) @(negedge clk);
    check(exp_q.size() == 0, "drain", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
